uart_rgb_pwm_ctrl: RTL and testbench
====================================

# uart_rgb_pwm_ctrl

Byte-stream command parser plus N-channel PWM dimmer, placed between the simpleuart byte interface and the SB_RGBA_DRV PWM inputs. It replaces fixed on/off colour presets with per-channel 8-bit duty set over UART, and it acknowledges every command. Duty updates are glitch-free: they take effect only at a PWM period boundary.

## Interface
- NUM_CH, 3, number of PWM channels, 1..10 (channel index is one ASCII digit)
- PWM_BITS, 8, PWM resolution, 1..8
- PRESCALE, 47, hw_clk cycles per PWM counter step (≥1)
- TIMEOUT_CYCLES, 120000, max idle hw_clk cycles between bytes of one command (≥2)

Ports:
- hw_clk  in  1  sole clock
- resetn  in  1  asynchronous, active-low reset
- rx_valid  in  1  one-cycle strobe: rx_data holds a received byte
- rx_data  in  8  received byte
- tx_valid  out  1  reply byte pending
- tx_data  out  8  reply byte, stable while tx_valid
- tx_ready  in  1  UART accepts tx_data this cycle
- pwm_out  out  NUM_CH  active-high PWM, bit i = channel i

Reset is asynchronous and active-low on resetn; hw_clk is the only clock.

## Operation
- Commands (ASCII): `S c h h` sets the duty of channel c ('0'..'0'+NUM_CH-1); hh is a hex byte (0-9, A-F, a-f). `X` zeroes every duty.
- Valid command: reply 'K'. Bad channel, bad hex digit, unknown opcode or timeout: reply '!', discard the partial command.
- The applied duty is hh >> (8-PWM_BITS).
- Parser states:
  - IDLE: 'S' → GET_CH. 'X' → REPLY('K'). Any other byte → REPLY('!').
  - GET_CH: valid digit → latch index, go to GET_HI. Otherwise → REPLY('!').
  - GET_HI: hex digit → latch high nibble, go to GET_LO. Otherwise → REPLY('!').
  - GET_LO: hex digit → write the pending duty for the channel, go to REPLY('K'). Otherwise → REPLY('!').
  - REPLY: tx_valid=1 until a cycle with tx_ready=1, then IDLE. rx bytes arriving in REPLY are dropped.
- Timeout: in GET_CH, GET_HI or GET_LO, TIMEOUT_CYCLES cycles without rx_valid → REPLY('!'). The counter clears on every accepted byte.
- PWM:
  - A prescaler counts 0..PRESCALE-1 and steps a free-running PWM_BITS counter cnt.
  - pwm_out[i] = (active_duty[i] > cnt), registered.
  - Duty 0 gives a constant low output. Duty 2^PWM_BITS-1 gives high for all but one step.
  - pending→active copy for all channels happens on the step where cnt wraps from max to 0.
  - An `X` command clears pending and active duty immediately.

## Timing
- Reset values: tx_valid=0, tx_data=8'h00, pwm_out=0, every duty (pending and active)=0, state IDLE, cnt=0, prescaler=0.
- Reply: tx_valid rises the cycle after the terminating rx_valid. tx_data is valid in the same cycle.
- pwm_out changes one cycle after cnt changes.
- A new duty appears in the first full PWM period after it is written. Latency is at most 2^PWM_BITS·PRESCALE+2 cycles.
- rx_valid in the same cycle the timeout fires: the byte is processed and the timeout is ignored.
- rx_valid while tx_valid=1: dropped; the state is unchanged.
- resetn low at any point: all state returns to reset values asynchronously. Any in-flight reply is abandoned.

## Structure
- Shared package uart_rgb_pkg holds:
  - Parser state enum
  - ASCII constants ('S', 'X', 'K', '!')
  - Hex-decode function (byte → {valid, nibble})
- Sub-module pwm_channel: one per channel, generated NUM_CH times. It holds the pending/active duty registers, the compare and the output register. It takes the shared cnt and a wrap strobe.
- The top level holds the parser FSM, the timeout counter, the prescaler and the PWM counter.

## Test plan
- Reset then idle: pwm_out=3'b000 and tx_valid=0 for 2·256·PRESCALE cycles.
- Send "S1FF" with tx_ready=1: tx_data='K'. From the next period, pwm_out[1] is high 255 of 256 steps; channels 0 and 2 stay low.
- Send "S080", then "S0a0" mid-period: the current period completes at duty 0x80 and the next period runs at 0xA0. No runt pulse appears.
- Send "S3", "S0G" and "Q" with NUM_CH=3: each replies '!'. Duties are unchanged.
- Send "S2" then no byte for TIMEOUT_CYCLES: '!' is sent. A following "S210" is accepted with 'K'.
- Hold tx_ready=0 for 50 cycles after "X": tx_valid and tx_data='K' stay stable. Bytes sent meanwhile are dropped. Assert resetn=0 mid-wait: tx_valid→0 immediately.

Source files
------------

// File: rtl/uart_rgb_pkg.sv
// Shared types and helpers for the UART-controlled RGB PWM dimmer.
package uart_rgb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_CH,
    ST_GET_HI,
    ST_GET_LO,
    ST_REPLY
  } parser_state_t;

  localparam logic [7:0] ASCII_S    = 8'h53;
  localparam logic [7:0] ASCII_X    = 8'h58;
  localparam logic [7:0] ASCII_K    = 8'h4B;
  localparam logic [7:0] ASCII_BANG = 8'h21;
  localparam logic [7:0] ASCII_0    = 8'h30;

  typedef struct packed {
    logic       valid;
    logic [3:0] nibble;
  } hex_nib_t;

  // ASCII hex digit (either case) to nibble, with a validity flag
  function automatic hex_nib_t hex_decode(input logic [7:0] b);
    hex_nib_t r;
    r.valid  = 1'b1;
    r.nibble = 4'h0;
    if (b >= 8'h30 && b <= 8'h39)      r.nibble = 4'(b - 8'h30);
    else if (b >= 8'h41 && b <= 8'h46) r.nibble = 4'(b - 8'h37);
    else if (b >= 8'h61 && b <= 8'h66) r.nibble = 4'(b - 8'h57);
    else                               r.valid  = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: pending/active duty pair, compare against the shared counter.
module pwm_channel
  import uart_rgb_pkg::*;
#(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [PWM_BITS-1:0] i_cnt,
  input  logic                i_wrap,
  input  logic                i_wr,
  input  logic [PWM_BITS-1:0] i_duty,
  input  logic                i_clr,
  output logic                o_pwm
);

  logic [PWM_BITS-1:0] r_pending;
  logic [PWM_BITS-1:0] r_active;
  logic                r_pwm;

  // Active duty only moves at the period wrap, so a running period is never cut short
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pending <= '0;
      r_active  <= '0;
      r_pwm     <= 1'b0;
    end else begin
      r_pwm <= (r_active > i_cnt);
      if (i_clr) begin
        r_pending <= '0;
        r_active  <= '0;
      end else begin
        if (i_wrap) r_active  <= r_pending;
        if (i_wr)   r_pending <= i_duty;
      end
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/uart_rgb_pwm_ctrl.sv
// UART byte-command parser ("S c h h" / "X") driving NUM_CH glitch-free PWM channels.
module uart_rgb_pwm_ctrl
  import uart_rgb_pkg::*;
#(
  parameter int unsigned NUM_CH         = 3,
  parameter int unsigned PWM_BITS       = 8,
  parameter int unsigned PRESCALE       = 47,
  parameter int unsigned TIMEOUT_CYCLES = 120000
) (
  input  logic              hw_clk,
  input  logic              resetn,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic [NUM_CH-1:0] pwm_out
);

  localparam int unsigned PRE_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned TO_W       = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned CH_W       = 4;
  localparam int unsigned DUTY_SHIFT = 8 - PWM_BITS;
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  logic [PRE_W-1:0]    r_pre;
  logic [PWM_BITS-1:0] r_cnt;
  logic                w_step;
  logic                w_wrap;

  parser_state_t r_state, w_state_nxt;
  logic [CH_W-1:0]     r_ch, w_ch_nxt;
  logic [3:0]          r_hi, w_hi_nxt;
  logic [TO_W-1:0]     r_to, w_to_nxt;
  logic                r_tx_valid;
  logic [7:0]          r_tx_data, w_tx_data_nxt;
  logic                w_timeout;
  logic                w_wr;
  logic                w_clr;
  logic [PWM_BITS-1:0] w_duty;
  hex_nib_t            w_hex;

  assign w_step = (r_pre == PRE_W'(PRESCALE - 1));
  assign w_wrap = w_step && (r_cnt == CNT_MAX);

  // Prescaler and free-running PWM counter
  always_ff @(posedge hw_clk or negedge resetn) begin
    if (!resetn) begin
      r_pre <= '0;
      r_cnt <= '0;
    end else if (w_step) begin
      r_pre <= '0;
      r_cnt <= r_cnt + 1'b1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  assign w_hex     = hex_decode(rx_data);
  assign w_duty    = PWM_BITS'({r_hi, w_hex.nibble} >> DUTY_SHIFT);
  assign w_timeout = (r_to == TO_W'(TIMEOUT_CYCLES - 1)) && !rx_valid;

  // Parser state register
  always_ff @(posedge hw_clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= ST_IDLE;
      r_ch       <= '0;
      r_hi       <= '0;
      r_to       <= '0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_ch       <= w_ch_nxt;
      r_hi       <= w_hi_nxt;
      r_to       <= w_to_nxt;
      r_tx_valid <= (w_state_nxt == ST_REPLY);
      r_tx_data  <= w_tx_data_nxt;
    end
  end

  // Next-state: an accepted byte or a non-GET state clears the idle counter
  always_comb begin
    w_state_nxt   = r_state;
    w_ch_nxt      = r_ch;
    w_hi_nxt      = r_hi;
    w_to_nxt      = '0;
    w_tx_data_nxt = r_tx_data;
    w_wr          = 1'b0;
    w_clr         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (rx_valid) begin
          w_state_nxt = ST_REPLY;
          if (rx_data == ASCII_S) begin
            w_state_nxt = ST_GET_CH;
          end else if (rx_data == ASCII_X) begin
            w_clr         = 1'b1;
            w_tx_data_nxt = ASCII_K;
          end else begin
            w_tx_data_nxt = ASCII_BANG;
          end
        end
      end
      ST_GET_CH, ST_GET_HI, ST_GET_LO: begin
        if (rx_valid) begin
          w_state_nxt   = ST_REPLY;
          w_tx_data_nxt = ASCII_BANG;
          if (r_state == ST_GET_CH) begin
            if (rx_data >= ASCII_0 && rx_data < 8'(ASCII_0 + NUM_CH)) begin
              w_ch_nxt    = CH_W'(rx_data - ASCII_0);
              w_state_nxt = ST_GET_HI;
            end
          end else if (w_hex.valid) begin
            if (r_state == ST_GET_HI) begin
              w_hi_nxt    = w_hex.nibble;
              w_state_nxt = ST_GET_LO;
            end else begin
              w_wr          = 1'b1;
              w_tx_data_nxt = ASCII_K;
            end
          end
        end else if (w_timeout) begin
          w_state_nxt   = ST_REPLY;
          w_tx_data_nxt = ASCII_BANG;
        end else begin
          w_to_nxt = r_to + 1'b1;
        end
      end
      ST_REPLY: begin
        if (tx_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign tx_valid = r_tx_valid;
  assign tx_data  = r_tx_data;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    pwm_channel #(.PWM_BITS(PWM_BITS)) u_ch (
      .i_clk   (hw_clk),
      .i_rst_n (resetn),
      .i_cnt   (r_cnt),
      .i_wrap  (w_wrap),
      .i_wr    (w_wr && (r_ch == CH_W'(gi))),
      .i_duty  (w_duty),
      .i_clr   (w_clr),
      .o_pwm   (pwm_out[gi])
    );
  end

endmodule

// File: tb/tb_uart_rgb_pwm_ctrl.sv
// Randomized bench for uart_rgb_pwm_ctrl against a cycle-count based reference model.
module tb_uart_rgb_pwm_ctrl;

  localparam int NUM_CH   = 3;
  localparam int PWM_BITS = 8;
  localparam int P        = 2;
  localparam int T        = 200;
  localparam int PERIOD   = (1 << PWM_BITS) * P;

  logic              hw_clk = 1'b0;
  logic              resetn = 1'b0;
  logic              rx_valid = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              tx_valid;
  logic [7:0]        tx_data;
  logic              tx_ready = 1'b1;
  logic [NUM_CH-1:0] pwm_out;

  uart_rgb_pwm_ctrl #(
    .NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .PRESCALE(P), .TIMEOUT_CYCLES(T)
  ) dut (
    .hw_clk(hw_clk), .resetn(resetn), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .pwm_out(pwm_out)
  );

  always #5 hw_clk = ~hw_clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference: edges since reset give the counter; duties follow command events
  int unsigned  m_k;
  byte unsigned m_pend [NUM_CH];
  byte unsigned m_act  [NUM_CH];
  bit           ev_wr = 1'b0;
  bit           ev_clr = 1'b0;
  int           ev_ch = 0;
  byte unsigned ev_duty = 8'h00;

  always @(posedge hw_clk) begin
    logic [NUM_CH-1:0] e;
    int cnt_b;
    #1;
    if (!resetn) begin
      m_k = 0;
      for (int i = 0; i < NUM_CH; i++) begin m_pend[i] = 0; m_act[i] = 0; end
    end else begin
      m_k++;
      cnt_b = int'(((m_k - 1) / P) % (1 << PWM_BITS));
      for (int i = 0; i < NUM_CH; i++) e[i] = (int'(m_act[i]) > cnt_b);
      check_eq("pwm", 32'(pwm_out), 32'(e));
      if (m_k % PERIOD == 0)
        for (int i = 0; i < NUM_CH; i++) m_act[i] = m_pend[i];
      if (ev_wr) m_pend[ev_ch] = ev_duty;
      if (ev_clr)
        for (int i = 0; i < NUM_CH; i++) begin m_pend[i] = 0; m_act[i] = 0; end
    end
  end

  function automatic int hexval(input byte unsigned b);
    string dl = "0123456789abcdef";
    string du = "0123456789ABCDEF";
    for (int i = 0; i < 16; i++)
      if (b == dl.getc(i) || b == du.getc(i)) return i;
    return -1;
  endfunction

  // Expected reply, terminating byte index and duty effect of one command string
  function automatic void ref_cmd(input string s, output int term, output byte unsigned rep,
                                  output bit wr, output int ch, output byte unsigned duty,
                                  output bit clr);
    int hi, lo;
    term = 0; rep = 8'h21; wr = 1'b0; ch = 0; duty = 8'h00; clr = 1'b0;
    if (s.getc(0) == 8'h58) begin rep = 8'h4B; clr = 1'b1; return; end
    if (s.getc(0) != 8'h53) return;
    term = 1;
    ch = int'(s.getc(1)) - 48;
    if (ch < 0 || ch >= NUM_CH) begin ch = 0; return; end
    term = 2;
    hi = hexval(s.getc(2));
    if (hi < 0) return;
    term = 3;
    lo = hexval(s.getc(3));
    if (lo < 0) return;
    rep = 8'h4B; wr = 1'b1;
    duty = 8'((hi * 16 + lo) >> (8 - PWM_BITS));
  endfunction

  task automatic send_byte(input byte unsigned b, input bit wr, input int ch,
                           input byte unsigned d, input bit clr);
    rx_data = b; rx_valid = 1'b1;
    ev_wr = wr; ev_ch = ch; ev_duty = d; ev_clr = clr;
    @(negedge hw_clk);
    rx_valid = 1'b0; ev_wr = 1'b0; ev_clr = 1'b0;
  endtask

  task automatic send_cmd(input string s, input int gap_max);
    int term, ch;
    byte unsigned rep, duty;
    bit wr, clr;
    ref_cmd(s, term, rep, wr, ch, duty, clr);
    for (int i = 0; i <= term; i++) begin
      if (i > 0) repeat ($urandom_range(gap_max, 0)) @(negedge hw_clk);
      send_byte(s.getc(i), (i == term) && wr, ch, duty, (i == term) && clr);
      if (i < term) check_eq({"busy_", s}, 32'(tx_valid), 0);
    end
    check_eq({"txv_", s}, 32'(tx_valid), 1);
    check_eq({"txd_", s}, 32'(tx_data), 32'(rep));
    @(negedge hw_clk);
    check_eq({"ack_", s}, 32'(tx_valid), 0);
  endtask

  task automatic wait_wrap();
    do @(negedge hw_clk); while (m_k % PERIOD != 0);
  endtask

  task automatic count_high(input int ch, output int n);
    n = 0;
    repeat (PERIOD) begin
      @(negedge hw_clk);
      n += int'(pwm_out[ch]);
    end
  endtask

  function automatic byte unsigned hexchar(input int nib, input bit upper);
    if (nib < 10) return 8'(48 + nib);
    return 8'((upper ? 65 : 97) + nib - 10);
  endfunction

  initial begin
    int n0, n1, n2;
    string s;
    string bad_op = "QsxK";
    string bad_ch = "39/A";
    string bad_hx = "Gg/:@_";

    bad_hx.putc(5, 8'h60);

    repeat (3) @(negedge hw_clk);
    check_eq("rst_txv", 32'(tx_valid), 0);
    check_eq("rst_txd", 32'(tx_data), 0);
    check_eq("rst_pwm", 32'(pwm_out), 0);
    resetn = 1'b1;

    repeat (2 * PERIOD) @(negedge hw_clk);
    check_eq("idle_txv", 32'(tx_valid), 0);

    send_cmd("S1FF", 0);
    wait_wrap();
    fork
      count_high(1, n1);
      count_high(0, n0);
      count_high(2, n2);
    join
    check_eq("ff_high", 32'(n1), 32'(255 * P));
    check_eq("ff_ch0", 32'(n0), 0);
    check_eq("ff_ch2", 32'(n2), 0);

    send_cmd("S080", 0);
    wait_wrap();
    fork
      count_high(0, n0);
      begin repeat (200) @(negedge hw_clk); send_cmd("S0a0", 0); end
    join
    check_eq("d80_period", 32'(n0), 32'(8'h80 * P));
    count_high(0, n0);
    check_eq("da0_period", 32'(n0), 32'(8'hA0 * P));

    send_cmd("S3", 0);
    send_cmd("S0G", 0);
    send_cmd("Q", 0);

    send_byte("S", 0, 0, 0, 0);
    send_byte("2", 0, 0, 0, 0);
    repeat (T - 1) @(negedge hw_clk);
    check_eq("to_early", 32'(tx_valid), 0);
    @(negedge hw_clk);
    check_eq("to_txv", 32'(tx_valid), 1);
    check_eq("to_txd", 32'(tx_data), 32'(8'h21));
    @(negedge hw_clk);
    send_cmd("S210", 5);

    send_byte("S", 0, 0, 0, 0);
    send_byte("2", 0, 0, 0, 0);
    repeat (T - 1) @(negedge hw_clk);
    send_byte("1", 0, 0, 0, 0);
    check_eq("to_race_busy", 32'(tx_valid), 0);
    send_byte("0", 1, 2, 8'h10, 0);
    check_eq("to_race_txd", 32'(tx_data), 32'(8'h4B));
    @(negedge hw_clk);

    for (int it = 0; it < 40; it++) begin
      int r, ch, d, pos;
      r  = int'($urandom_range(9, 0));
      ch = int'($urandom_range(NUM_CH - 1, 0));
      d  = int'($urandom_range(255, 0));
      s  = "S000";
      s.putc(1, 8'(48 + ch));
      s.putc(2, hexchar(d / 16, 1'($urandom_range(1, 0))));
      s.putc(3, hexchar(d % 16, 1'($urandom_range(1, 0))));
      if (r == 6) begin
        s = "X";
      end else if (r > 6) begin
        pos = int'($urandom_range(3, 0));
        if (pos == 0)      s.putc(0, bad_op.getc(int'($urandom_range(3, 0))));
        else if (pos == 1) s.putc(1, bad_ch.getc(int'($urandom_range(3, 0))));
        else               s.putc(pos, bad_hx.getc(int'($urandom_range(5, 0))));
      end
      send_cmd(s, 20);
      repeat ($urandom_range(300, 0)) @(negedge hw_clk);
    end

    tx_ready = 1'b0;
    send_byte("X", 0, 0, 0, 1);
    for (int i = 0; i < 25; i++) begin
      send_byte((i % 2 == 0) ? 8'h53 : 8'h31, 0, 0, 0, 0);
      check_eq("hold_txv", 32'(tx_valid), 1);
      @(negedge hw_clk);
      check_eq("hold_txd", 32'(tx_data), 32'(8'h4B));
    end
    tx_ready = 1'b1;
    @(negedge hw_clk);
    check_eq("hold_done", 32'(tx_valid), 0);
    send_cmd("S0FF", 0);

    tx_ready = 1'b0;
    send_byte("X", 0, 0, 0, 1);
    repeat (10) @(negedge hw_clk);
    #3 resetn = 1'b0;
    #1;
    check_eq("arst_txv", 32'(tx_valid), 0);
    check_eq("arst_txd", 32'(tx_data), 0);
    check_eq("arst_pwm", 32'(pwm_out), 0);
    @(negedge hw_clk);
    resetn = 1'b1;
    tx_ready = 1'b1;
    repeat (20) @(negedge hw_clk);
    check_eq("post_rst_txv", 32'(tx_valid), 0);
    send_cmd("S2c3", 3);
    wait_wrap();
    count_high(2, n2);
    check_eq("post_rst_c3", 32'(n2), 32'(8'hC3 * P));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
